selftest_sequencer: RTL
=======================

// Module: selftest_sequencer
// PURPOSE
//   Parametrised power-on self-test sequencer for the board display.
//   Steps the LED matrix through red, green and yellow, then exercises the 7-segment digits.
//   Digit mode is selectable: all digits blink together, or a single lit digit walks across positions.
//   Drives matrix/number data buses and a beeper enable; signals done to the top-level mode mux.
// PARAMETERS
//   TICK_DIV     50_000_000  clk cycles per step period (>=2, even)
//   PIX          64          matrix pixels; 2 bits (R,G) per pixel
//   DIGITS       8           7-seg digits; 4-bit nibble per digit
//   BLINK_STEPS  3           step periods spent in DIGIT phase when WALK_MODE=0 (>=1)
//   WALK_MODE    0           0 = all digits blink together; 1 = single digit walks LSB->MSB, one period each
//   BEEP_CYC     5_000_000   beep_en length at the start of each step (1..TICK_DIV)
// PORTS
//   clk           in   1          system clock
//   rst           in   1          synchronous reset, active-high
//   start         in   1          1-cycle pulse; begins sequence from IDLE or DONE
//   abort         in   1          1-cycle pulse; cancels the running sequence
//   busy          out  1          high in RED..DIGIT
//   done          out  1          high in DONE
//   step          out  3          state code: IDLE=0 RED=1 GREEN=2 YELLOW=3 DIGIT=4 DONE=5
//   matrix_data   out  2*PIX      {PIX{RG}}, R is the MSB of each pair
//   numbers_data  out  4*DIGITS   nibble k drives digit k; 4'hF = blank, 4'h8 = all segments lit
//   beep_en       out  1          beeper gate
// BEHAVIOUR
//   - One clock, synchronous active-high reset. No derived clocks; the step period comes from a clk-enable.
//   - Reset values: state IDLE, prescaler 0, digit index 0.
//     Reset outputs: busy=0, done=0, step=0, matrix_data=0, numbers_data=all 4'hF, beep_en=0.
//   - Prescaler cnt, width $clog2(TICK_DIV).
//     Runs only while busy; wraps TICK_DIV-1 -> 0.
//     tick = busy && cnt==TICK_DIV-1.
//     half = cnt < TICK_DIV/2, i.e. blink is on in the first half of each period.
//   - start while state is IDLE or DONE: next edge -> RED, cnt=0, digit index=0.
//   - start while busy is ignored.
//   - rst beats abort; abort beats start.
//   - abort while busy: next edge -> IDLE, cnt=0, outputs blanked.
//   - abort in IDLE or DONE has no effect.
//   - State transitions occur on the edge where tick=1: RED->GREEN->YELLOW->DIGIT.
//     RED, GREEN and YELLOW each last exactly TICK_DIV cycles.
//   - DIGIT lasts BLINK_STEPS periods (WALK_MODE=0) or DIGITS periods (WALK_MODE=1).
//     A period counter advances on tick; the last tick moves the state to DONE.
//   - DONE holds until start or rst. No auto-restart.
//   - Outputs are combinational from registered state/cnt; zero extra latency.
//   - Matrix colour: RED=2'b10, GREEN=2'b01, YELLOW=2'b11, all other states 2'b00.
//     matrix_data = {PIX{colour & {2{half}}}}.
//   - Numbers are all 4'hF outside DIGIT. Inside DIGIT:
//     WALK_MODE=0: every nibble = half ? 4'h8 : 4'hF.
//     WALK_MODE=1: nibble k = (k==idx && half) ? 4'h8 : 4'hF; idx = current DIGIT period (0..DIGITS-1).
//   - beep_en = busy && cnt < BEEP_CYC. Always 0 in IDLE and DONE.
// STRUCTURE
//   - selftest_pkg holds:
//     state enum/codes; colour constants C_RED, C_GREEN, C_YELLOW, C_OFF; NIB_BLANK=4'hF; NIB_ALL=4'h8.
//   - Sub-module step_prescaler: counter with sync clear and enable; outputs cnt, tick, half.
//     Reused by the music player.
//   - Top holds the FSM, the DIGIT period counter and the output decode.
// TESTING  (TICK_DIV=10, PIX=4, DIGITS=4, BLINK_STEPS=2, BEEP_CYC=3)
//   1 Reset: hold rst 3 cycles -> matrix_data=8'h00, numbers_data=16'hFFFF, step=0, busy=0, done=0, beep_en=0.
//   2 Full run, WALK_MODE=0: start at c0.
//     RED c1-10: matrix 8'hAA c1-5, 8'h00 c6-10; beep_en c1-3.
//     GREEN c11-20: matrix 8'h55 in the first half. YELLOW c21-30: matrix 8'hFF in the first half.
//     DIGIT c31-50: numbers 16'h8888 / 16'hFFFF alternating every 5 cycles.
//     c51: done=1, step=5, outputs blank.
//   3 Abort at 4th GREEN cycle -> next cycle step=0, busy=0, matrix 0, numbers 16'hFFFF.
//     A following start -> RED with cnt=0 and full-length periods.
//   4 WALK_MODE=1: DIGIT lasts 40 cycles.
//     First half of each period: 16'hFFF8, 16'hFF8F, 16'hF8FF, 16'h8FFF; then DONE.
//   5 start pulse mid-YELLOW is ignored (timing unchanged). start in DONE restarts at RED.
//   6 rst and start in the same cycle -> remains IDLE. abort and start together in DONE -> restarts at RED.

Source files
------------

// File: rtl/selftest_pkg.sv
// Shared state codes, matrix colours and digit nibbles for the display self-test.
// The music player reuses these constants.
package selftest_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RED    = 3'd1;
    localparam logic [2:0] S_GREEN  = 3'd2;
    localparam logic [2:0] S_YELLOW = 3'd3;
    localparam logic [2:0] S_DIGIT  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Each pixel is an {R,G} pair with R in the MSB.
    localparam logic [1:0] C_RED    = 2'b10;
    localparam logic [1:0] C_GREEN  = 2'b01;
    localparam logic [1:0] C_YELLOW = 2'b11;
    localparam logic [1:0] C_OFF    = 2'b00;

    localparam logic [3:0] NIB_BLANK = 4'hF;
    localparam logic [3:0] NIB_ALL   = 4'h8;

    function automatic logic [1:0] colour_of(input logic [2:0] s);
        case (s)
            S_RED:    return C_RED;
            S_GREEN:  return C_GREEN;
            S_YELLOW: return C_YELLOW;
            default:  return C_OFF;
        endcase
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running step-period counter with a synchronous clear and a count enable.
// It provides the period tick and the first-half blink phase.
module step_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    output logic [$clog2(TICK_DIV)-1:0] cnt,
    output logic                        tick,
    output logic                        half
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALFV = CW'(TICK_DIV / 2);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);
    assign half = (cnt < HALFV);

endmodule

// File: rtl/selftest_sequencer.sv
// Power-on display self-test: matrix red/green/yellow, then the 7-segment digits
// either blinking together or with one lit digit walking LSB to MSB.
module selftest_sequencer
    import selftest_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int PIX         = 64,
    parameter int DIGITS      = 8,
    parameter int BLINK_STEPS = 3,
    parameter int WALK_MODE   = 0,
    parameter int BEEP_CYC    = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            step,
    output logic [2*PIX-1:0]      matrix_data,
    output logic [4*DIGITS-1:0]   numbers_data,
    output logic                  beep_en
);

    localparam int NPER = (WALK_MODE != 0) ? DIGITS : BLINK_STEPS;
    localparam int IW   = (NPER > 1) ? $clog2(NPER) : 1;
    localparam int CW   = $clog2(TICK_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPER - 1);

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          half;
    logic          start_go;
    logic          abort_go;
    logic [1:0]    colour;

    assign busy     = (state == S_RED) || (state == S_GREEN) ||
                      (state == S_YELLOW) || (state == S_DIGIT);
    assign done     = (state == S_DONE);
    assign step     = state;
    // start and abort are mutually exclusive by qualification, so abort winning is implicit.
    assign abort_go = abort && busy;
    assign start_go = start && !busy;

    step_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_go || abort_go),
        .en   (busy),
        .cnt  (cnt),
        .tick (tick),
        .half (half)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else if (abort_go) begin
            state <= S_IDLE;
            idx   <= '0;
        end else if (start_go) begin
            state <= S_RED;
            idx   <= '0;
        end else if (tick) begin
            case (state)
                S_RED:    state <= S_GREEN;
                S_GREEN:  state <= S_YELLOW;
                S_YELLOW: state <= S_DIGIT;
                S_DIGIT: begin
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default:  state <= state;
            endcase
        end
    end

    always_comb begin
        colour       = colour_of(state);
        matrix_data  = {PIX{colour & {2{half}}}};
        numbers_data = {DIGITS{NIB_BLANK}};
        if (state == S_DIGIT && half) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (WALK_MODE == 0 || idx == IW'(k)) begin
                    numbers_data[4*k +: 4] = NIB_ALL;
                end
            end
        end
        beep_en = busy && (int'(cnt) < BEEP_CYC);
    end

endmodule
